// File: rtl/alu_issue_ctrl_if.sv
// ID/EX issue handshake bundle for alu_issue_ctrl.
// The master side is the ID stage and hazard unit. The slave side is the issue controller.
interface alu_issue_ctrl_if;
    logic        In_Valid;
    logic [31:0] In_Instr;
    logic        In_Ready;
    logic        Stall;
    logic        Flush;
    logic        Valid_EX;
    logic [31:0] Instr_EX;
    logic [4:0]  Src_SEL;
    logic [4:0]  Shamt_EX;
    logic [15:0] Imm_EX;
    logic        MDU_Start;
    logic        MDU_Busy;
    logic        Illegal;

    modport master (
        output In_Valid, In_Instr, Stall, Flush,
        input  In_Ready, Valid_EX, Instr_EX, Src_SEL, Shamt_EX, Imm_EX,
               MDU_Start, MDU_Busy, Illegal
    );

    modport slave (
        input  In_Valid, In_Instr, Stall, Flush,
        output In_Ready, Valid_EX, Instr_EX, Src_SEL, Shamt_EX, Imm_EX,
               MDU_Start, MDU_Busy, Illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ID/EX issue controller: decodes the ALU operand source, registers the EX slot, and schedules the shared MDU.
// Optional macro ILLEGAL_INSTR_EN: undecodable encodings issue as live slots with Src_SEL=31 and Illegal=1.
module alu_issue_ctrl #(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    alu_issue_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Returns {legal, src_sel} for one instruction word.
    function automatic logic [5:0] decode_instr(input logic [31:0] instr);
        logic [5:0] res;
        res = {1'b0, 5'd0};
        case (instr[31:26])
            6'h00: begin
                case (instr[5:0])
                    6'h00, 6'h02, 6'h03: res = {1'b1, 5'd4};
                    6'h04, 6'h06, 6'h07: res = {1'b1, 5'd3};
                    6'h08, 6'h09, 6'h0C, 6'h0D,
                    6'h10, 6'h11, 6'h12, 6'h13,
                    6'h18, 6'h19, 6'h1A, 6'h1B,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:        res = {1'b1, 5'd0};
                    default:             res = {1'b0, 5'd0};
                endcase
            end
            6'h02, 6'h03:                res = {1'b1, 5'd0};
            6'h0C, 6'h0D, 6'h0E, 6'h0F:  res = {1'b1, 5'd1};
            6'h04, 6'h05, 6'h08, 6'h09,
            6'h0A, 6'h0B, 6'h23, 6'h2B:  res = {1'b1, 5'd2};
            default:                     res = {1'b0, 5'd0};
        endcase
        return res;
    endfunction

    logic [5:0]       opcode_s;
    logic [5:0]       funct_s;
    logic [5:0]       dec_s;
    logic             legal_s;
    logic [4:0]       dec_src_s;
    logic             mdu_op_s;
    logic             hilo_s;
    logic             block_s;
    logic             ready_s;
    logic             accept_s;
    logic             ld_valid_s;
    logic [4:0]       ld_src_s;

    logic             valid_r;
    logic [31:0]      instr_r;
    logic [4:0]       src_r;
    logic [4:0]       shamt_r;
    logic [15:0]      imm_r;
    logic             start_r;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;

    // Instruction classification and the issue handshake.
    always_comb begin
        opcode_s  = bus.In_Instr[31:26];
        funct_s   = bus.In_Instr[5:0];
        dec_s     = decode_instr(bus.In_Instr);
        legal_s   = dec_s[5];
        dec_src_s = dec_s[4:0];
        mdu_op_s  = (opcode_s == 6'h00) && (funct_s[5:2] == 4'b0110);
        // HI/LO reads are R-type only; I-type immediates can alias the funct bits.
        hilo_s    = (opcode_s == 6'h00) && ((funct_s == 6'h10) || (funct_s == 6'h12));
        block_s   = busy_r && (mdu_op_s || hilo_s);
        ready_s   = !bus.Stall && !bus.Flush && !block_s;
        accept_s  = bus.In_Valid && ready_s;
    end

`ifdef ILLEGAL_INSTR_EN
    logic ld_illegal_s;
    logic illegal_r;

    // Values loaded into the EX slot: undecodable words stay live so exceptions can see them.
    always_comb begin
        ld_valid_s   = 1'b1;
        ld_src_s     = 5'd0;
        ld_illegal_s = 1'b0;
        if (legal_s) begin
            ld_src_s     = dec_src_s;
            ld_illegal_s = 1'b0;
        end else begin
            ld_src_s     = 5'd31;
            ld_illegal_s = 1'b1;
        end
    end

    // Illegal flag follows loads and clears on bubbles; flush and stall hold it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            illegal_r <= 1'b0;
        end else if (bus.Flush || bus.Stall) begin
            illegal_r <= illegal_r;
        end else if (accept_s) begin
            illegal_r <= ld_illegal_s;
        end else begin
            illegal_r <= 1'b0;
        end
    end

    assign bus.Illegal = illegal_r;
`else
    // Values loaded into the EX slot: undecodable words become a silent NOP.
    always_comb begin
        ld_valid_s = 1'b0;
        ld_src_s   = 5'd0;
        if (legal_s) begin
            ld_valid_s = 1'b1;
            ld_src_s   = dec_src_s;
        end else begin
            ld_valid_s = 1'b0;
            ld_src_s   = 5'd0;
        end
    end

    assign bus.Illegal = 1'b0;
`endif

    // EX slot register: flush beats stall, stall beats load, otherwise a bubble.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= 1'b0;
            instr_r <= 32'd0;
            src_r   <= 5'd0;
            shamt_r <= 5'd0;
            imm_r   <= 16'd0;
        end else if (bus.Flush) begin
            valid_r <= 1'b0;
        end else if (bus.Stall) begin
            valid_r <= valid_r;
        end else if (accept_s) begin
            valid_r <= ld_valid_s;
            instr_r <= bus.In_Instr;
            src_r   <= ld_src_s;
            shamt_r <= bus.In_Instr[10:6];
            imm_r   <= bus.In_Instr[15:0];
        end else begin
            valid_r <= 1'b0;
        end
    end

    // MDU start pulse is never held by a stall, so the unit cannot be started twice.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            start_r <= 1'b0;
        end else begin
            start_r <= accept_s && mdu_op_s;
        end
    end

    // MDU scheduler state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // MDU scheduler next state: once issued, an MDU op runs to completion.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && mdu_op_s) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // MDU scheduler outputs, registered alongside the state.
    always_comb begin
        busy_nxt_s = 1'b0;
        if (state_nxt_s == ST_BUSY) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    assign bus.In_Ready  = ready_s;
    assign bus.Valid_EX  = valid_r;
    assign bus.Instr_EX  = instr_r;
    assign bus.Src_SEL   = src_r;
    assign bus.Shamt_EX  = shamt_r;
    assign bus.Imm_EX    = imm_r;
    assign bus.MDU_Start = start_r;
    assign bus.MDU_Busy  = busy_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_issue_ctrl;

    localparam int MDU_CYC = 4;

    localparam logic [31:0] I_SLL  = 32'h0009_4140;
    localparam logic [31:0] I_ANDI = 32'h3128_FFFF;
    localparam logic [31:0] I_LW   = 32'h8D28_0004;
    localparam logic [31:0] I_SRAV = 32'h0128_4007;
    localparam logic [31:0] I_MULT = 32'h0109_0018;
    localparam logic [31:0] I_DIV  = 32'h0109_001A;
    localparam logic [31:0] I_MFLO = 32'h0000_4012;
    localparam logic [31:0] I_ADD  = 32'h0109_4020;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.MDU_CYCLES(MDU_CYC), .CNT_W(6)) dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic        m_valid;
    logic [31:0] m_instr;
    logic [4:0]  m_src;
    logic [4:0]  m_shamt;
    logic [15:0] m_imm;
    logic        m_start;
    logic        m_illegal;
    int          m_busy_left;
    logic        exp_ready;
    logic        got_ready;

    function automatic logic is_mdu(input logic [31:0] i);
        return (i[31:26] == 6'h00) && (i[5:0] >= 6'h18) && (i[5:0] <= 6'h1B);
    endfunction

    function automatic logic is_hilo(input logic [31:0] i);
        return (i[31:26] == 6'h00) && ((i[5:0] == 6'h10) || (i[5:0] == 6'h12));
    endfunction

    // Decode table from the instruction-set listing.
    function automatic void ref_decode(input logic [31:0] i, output logic legal, output logic [4:0] src);
        int op;
        int fn;
        op = int'(i[31:26]);
        fn = int'(i[5:0]);
        legal = 1'b1;
        src = 5'd0;
        if (op == 0) begin
            if (fn inside {0, 2, 3}) src = 5'd4;
            else if (fn inside {4, 6, 7}) src = 5'd3;
            else if (fn inside {8, 9, 12, 13, [16:19], [24:27], [32:39], 42, 43}) src = 5'd0;
            else legal = 1'b0;
        end else if (op inside {2, 3}) src = 5'd0;
        else if (op inside {[12:15]}) src = 5'd1;
        else if (op inside {4, 5, [8:11], 35, 43}) src = 5'd2;
        else legal = 1'b0;
    endfunction

    function automatic logic [61:0] model_vec();
        return {m_valid, m_instr, m_src, m_shamt, m_imm, m_start, (m_busy_left > 0), m_illegal};
    endfunction

    function automatic logic [61:0] dut_vec();
        return {bus.Valid_EX, bus.Instr_EX, bus.Src_SEL, bus.Shamt_EX, bus.Imm_EX,
                bus.MDU_Start, bus.MDU_Busy, bus.Illegal};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_instr = 32'd0; m_src = 5'd0; m_shamt = 5'd0; m_imm = 16'd0;
        m_start = 1'b0; m_illegal = 1'b0; m_busy_left = 0;
    endtask

    task automatic model_step(input logic acc, input logic [31:0] ins, input logic st, input logic fl);
        logic       legal;
        logic [4:0] src;
        ref_decode(ins, legal, src);
        if (acc && is_mdu(ins)) m_busy_left = MDU_CYC - 1;
        else if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
        m_start = acc && is_mdu(ins);
        if (fl) m_valid = 1'b0;
        else if (st) m_valid = m_valid;
        else if (acc) begin
            m_instr = ins; m_shamt = ins[10:6]; m_imm = ins[15:0];
`ifdef ILLEGAL_INSTR_EN
            m_valid = 1'b1; m_src = legal ? src : 5'd31; m_illegal = !legal;
`else
            m_valid = legal; m_src = legal ? src : 5'd0; m_illegal = 1'b0;
`endif
        end else begin
            m_valid = 1'b0; m_illegal = 1'b0;
        end
    endtask

    // Drives one cycle, samples In_Ready before the edge and advances the model at the edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
        bus.In_Valid = v; bus.In_Instr = ins; bus.Stall = st; bus.Flush = fl;
        #1;
        exp_ready = !st && !fl && !((m_busy_left > 0) && (is_mdu(ins) || is_hilo(ins)));
        got_ready = bus.In_Ready;
        @(posedge clk);
        model_step(v && exp_ready, ins, st, fl);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; bus.In_Valid = 1'b0; bus.In_Instr = 32'd0; bus.Stall = 1'b0; bus.Flush = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (dut_vec() !== 62'd0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", dut_vec()); end
        drive(1'b1, I_MULT, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        n_checks++;
        if (bus.MDU_Busy !== 1'b1) begin n_fail++; $display("FAIL busy_before_reset: got %b expected 1", bus.MDU_Busy); end
        apply_reset();
        n_checks++;
        if (dut_vec() !== 62'd0) begin n_fail++; $display("FAIL reset_mid_busy: got %h expected 0", dut_vec()); end
        drive(1'b1, I_MFLO, 1'b0, 1'b0);
        n_checks++;
        if (got_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", got_ready); end
        drive(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_decode();
        drive(1'b1, I_SLL, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Valid_EX, bus.Src_SEL, bus.Shamt_EX} !== {1'b1, 5'd4, 5'd5}) begin
            n_fail++; $display("FAIL decode_sll: got v=%b src=%0d sh=%0d expected v=1 src=4 sh=5", bus.Valid_EX, bus.Src_SEL, bus.Shamt_EX);
        end
        drive(1'b1, I_ANDI, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Valid_EX, bus.Src_SEL, bus.Imm_EX} !== {1'b1, 5'd1, 16'hFFFF}) begin
            n_fail++; $display("FAIL decode_andi: got v=%b src=%0d imm=%h expected v=1 src=1 imm=ffff", bus.Valid_EX, bus.Src_SEL, bus.Imm_EX);
        end
        drive(1'b1, I_LW, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Valid_EX, bus.Src_SEL, bus.Instr_EX} !== {1'b1, 5'd2, I_LW}) begin
            n_fail++; $display("FAIL decode_lw: got v=%b src=%0d instr=%h expected v=1 src=2 instr=%h", bus.Valid_EX, bus.Src_SEL, bus.Instr_EX, I_LW);
        end
        drive(1'b0, I_ADD, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL decode_bubble: got %h expected %h", dut_vec(), model_vec()); end
    endtask

    task automatic test_mdu();
        int busy_cycles;
        drive(1'b1, I_MULT, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Valid_EX, bus.MDU_Start, bus.MDU_Busy} !== 3'b111) begin
            n_fail++; $display("FAIL mult_issue: got v/start/busy=%b%b%b expected 111", bus.Valid_EX, bus.MDU_Start, bus.MDU_Busy);
        end
        busy_cycles = 1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, I_MFLO, 1'b0, 1'b0);
            n_checks++;
            if (got_ready !== (k == 3)) begin n_fail++; $display("FAIL mflo_hold_%0d: got ready=%b expected %b", k, got_ready, (k == 3)); end
            n_checks++;
            if (bus.MDU_Start !== 1'b0) begin n_fail++; $display("FAIL start_pulse_%0d: got %b expected 0", k, bus.MDU_Start); end
            if (bus.MDU_Busy === 1'b1) busy_cycles++;
        end
        n_checks++;
        if (busy_cycles != MDU_CYC - 1) begin n_fail++; $display("FAIL busy_length: got %0d expected %0d", busy_cycles, MDU_CYC - 1); end
        n_checks++;
        if ({bus.Valid_EX, bus.Instr_EX} !== {1'b1, I_MFLO}) begin n_fail++; $display("FAIL mflo_issue: got v=%b instr=%h", bus.Valid_EX, bus.Instr_EX); end
        drive(1'b1, I_MULT, 1'b0, 1'b0);
        drive(1'b1, I_ADD, 1'b0, 1'b0);
        n_checks++;
        if ({got_ready, bus.Valid_EX, bus.Instr_EX, bus.MDU_Busy} !== {1'b1, 1'b1, I_ADD, 1'b1}) begin
            n_fail++; $display("FAIL add_during_busy: got rdy=%b v=%b instr=%h busy=%b", got_ready, bus.Valid_EX, bus.Instr_EX, bus.MDU_Busy);
        end
        for (int k = 0; k < MDU_CYC; k++) drive(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_stall_flush();
        drive(1'b1, I_SRAV, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, I_ADD, 1'b1, 1'b0);
            n_checks++;
            if ({got_ready, bus.Valid_EX, bus.Src_SEL, bus.Instr_EX} !== {1'b0, 1'b1, 5'd3, I_SRAV}) begin
                n_fail++; $display("FAIL stall_hold_%0d: got rdy=%b v=%b src=%0d instr=%h", k, got_ready, bus.Valid_EX, bus.Src_SEL, bus.Instr_EX);
            end
        end
        drive(1'b1, I_ADD, 1'b1, 1'b1);
        n_checks++;
        if ({got_ready, bus.Valid_EX, bus.Src_SEL} !== {1'b0, 1'b0, 5'd3}) begin
            n_fail++; $display("FAIL stall_flush: got rdy=%b v=%b src=%0d expected 0 0 3", got_ready, bus.Valid_EX, bus.Src_SEL);
        end
    endtask

    task automatic test_flush_div();
        int busy_cycles;
        drive(1'b1, I_DIV, 1'b0, 1'b0);
        busy_cycles = (bus.MDU_Busy === 1'b1) ? 1 : 0;
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        n_checks++;
        if ({bus.Valid_EX, bus.MDU_Busy} !== 2'b01) begin n_fail++; $display("FAIL flush_div: got v=%b busy=%b expected 0 1", bus.Valid_EX, bus.MDU_Busy); end
        if (bus.MDU_Busy === 1'b1) busy_cycles++;
        for (int k = 0; k < MDU_CYC; k++) begin
            drive(1'b0, 32'd0, 1'b0, 1'b0);
            if (bus.MDU_Busy === 1'b1) busy_cycles++;
        end
        n_checks++;
        if (busy_cycles != MDU_CYC - 1) begin n_fail++; $display("FAIL flush_div_busy: got %0d expected %0d", busy_cycles, MDU_CYC - 1); end
    endtask

    task automatic test_back_to_back();
        int blocked;
        drive(1'b1, I_MULT, 1'b0, 1'b0);
        blocked = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, I_DIV, 1'b0, 1'b0);
            if (got_ready === 1'b1) break;
            blocked++;
        end
        n_checks++;
        if (blocked != MDU_CYC - 1) begin n_fail++; $display("FAIL b2b_blocked: got %0d expected %0d", blocked, MDU_CYC - 1); end
        n_checks++;
        if ({bus.Instr_EX, bus.MDU_Start, bus.MDU_Busy} !== {I_DIV, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL b2b_second_issue: got instr=%h start=%b busy=%b", bus.Instr_EX, bus.MDU_Start, bus.MDU_Busy);
        end
        for (int k = 0; k < MDU_CYC; k++) drive(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        drive(1'b1, I_BAD, 1'b0, 1'b0);
        n_checks++;
`ifdef ILLEGAL_INSTR_EN
        if ({bus.Valid_EX, bus.Src_SEL, bus.Illegal} !== {1'b1, 5'd31, 1'b1}) begin
            n_fail++; $display("FAIL illegal_decode: got v=%b src=%0d ill=%b expected 1 31 1", bus.Valid_EX, bus.Src_SEL, bus.Illegal);
        end
`else
        if ({bus.Valid_EX, bus.Illegal} !== 2'b00) begin
            n_fail++; $display("FAIL illegal_nop: got v=%b ill=%b expected 0 0", bus.Valid_EX, bus.Illegal);
        end
`endif
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.Valid_EX, bus.Illegal} !== 2'b00) begin n_fail++; $display("FAIL illegal_clear: got v=%b ill=%b expected 0 0", bus.Valid_EX, bus.Illegal); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int          kind;
        for (int n = 0; n < 400; n++) begin
            ins  = $urandom();
            kind = $urandom_range(0, 5);
            if (kind < 3) ins[31:26] = 6'h00;
            if (kind == 1) ins[5:0] = 6'h18 + 6'($urandom_range(0, 3));
            if (kind == 2) ins[5:0] = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12;
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
            n_checks++;
            if (got_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready_%0d: got %b expected %b", n, got_ready, exp_ready); end
            n_checks++;
            if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL rand_ex_%0d: got %h expected %h", n, dut_vec(), model_vec()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_decode();
        test_mdu();
        test_stall_flush();
        test_flush_div();
        test_back_to_back();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
